// File: rtl/rv32_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/exec/mem/wb, counts retired instructions
// and halts on a memory-wait timeout. Optional macro CTRL_ILLEGAL_HALT_EN halts on unknown opcodes.
module rv32_multicycle_ctrl #(
   parameter int XLEN     = 32,
   parameter int WAIT_MAX = 15,
   parameter int WAIT_W   = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     instr,
   input  logic            imem_ready,
   input  logic            dmem_ready,
   input  logic            br_taken,
   output logic            imem_req,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic            ir_we,
   output logic            pc_we,
   output logic            rf_we,
   output logic [1:0]      sel_pc,
   output logic [1:0]      wb_sel,
   output logic            op1_sel,
   output logic            op2_sel,
   output logic [2:0]      imm_sel,
   output logic [3:0]      alu_op,
   output logic            bus_err,
   output logic            halted,
`ifdef CTRL_ILLEGAL_HALT_EN
   output logic            illegal,
`endif
   output logic [XLEN-1:0] instret
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

   state_t            state_q, state_d;
   logic [6:0]        opcode_q, opcode_d;
   logic [2:0]        funct3_q, funct3_d;
   logic              f7b5_q, f7b5_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              bus_err_q, bus_err_d;
   logic [XLEN-1:0]   instret_q, instret_d;
   logic              opc_known;
   logic              retire;
   logic              unused_instr;
`ifdef CTRL_ILLEGAL_HALT_EN
   logic              illegal_q, illegal_d;
   assign illegal = illegal_q;
`endif

   assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};
   assign bus_err      = bus_err_q;
   assign instret      = instret_q;
   // The DECODE-stage NOP moves the PC but is not a retired instruction.
   assign retire       = pc_we && (state_q != S_DECODE);

   always_comb begin
      case (opcode_q)
         OPC_OP, OPC_OPIMM, OPC_AUIPC, OPC_LOAD, OPC_STORE,
         OPC_BRANCH, OPC_JAL, OPC_JALR: opc_known = 1'b1;
         default:                       opc_known = 1'b0;
      endcase
   end

   always_comb begin : next_state
      state_d   = state_q;
      opcode_d  = opcode_q;
      funct3_d  = funct3_q;
      f7b5_d    = f7b5_q;
      wait_d    = wait_q;
      bus_err_d = bus_err_q;
      instret_d = instret_q + XLEN'(retire);
`ifdef CTRL_ILLEGAL_HALT_EN
      illegal_d = illegal_q;
`endif
      case (state_q)
         S_FETCH: begin
            if (imem_ready) begin
               opcode_d = instr[6:0];
               funct3_d = instr[14:12];
               f7b5_d   = instr[30];
               state_d  = S_DECODE;
            end else if (wait_q == WAIT_LIM) begin
               bus_err_d = 1'b1;
               state_d   = S_HALT;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_DECODE: begin
            if (opcode_q == OPC_LUI) state_d = S_WB;
            else if (opc_known)      state_d = S_EXEC;
            else begin
`ifdef CTRL_ILLEGAL_HALT_EN
               illegal_d = 1'b1;
               state_d   = S_HALT;
`else
               state_d   = S_FETCH;
`endif
            end
         end
         S_EXEC: begin
            if (opcode_q == OPC_LOAD || opcode_q == OPC_STORE) state_d = S_MEM;
            else if (opcode_q == OPC_BRANCH)                    state_d = S_FETCH;
            else                                                state_d = S_WB;
         end
         S_MEM: begin
            if (dmem_ready) begin
               state_d = (opcode_q == OPC_LOAD) ? S_WB : S_FETCH;
            end else if (wait_q == WAIT_LIM) begin
               bus_err_d = 1'b1;
               state_d   = S_HALT;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_WB:    state_d = S_FETCH;
         default: state_d = S_HALT;
      endcase
      if (state_d != state_q) wait_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         opcode_q  <= '0;
         funct3_q  <= '0;
         f7b5_q    <= 1'b0;
         wait_q    <= '0;
         bus_err_q <= 1'b0;
         instret_q <= '0;
`ifdef CTRL_ILLEGAL_HALT_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         funct3_q  <= funct3_d;
         f7b5_q    <= f7b5_d;
         wait_q    <= wait_d;
         bus_err_q <= bus_err_d;
         instret_q <= instret_d;
`ifdef CTRL_ILLEGAL_HALT_EN
         illegal_q <= illegal_d;
`endif
      end
   end

   // Handshake: imem_req/dmem_req stay high until the matching ready is seen; the access
   // completes in the cycle where req=1 and ready=1, and the FSM advances on that edge.
   always_comb begin : outputs
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      rf_we    = 1'b0;
      sel_pc   = 2'b00;
      wb_sel   = 2'b00;
      op1_sel  = 1'b0;
      op2_sel  = 1'b0;
      imm_sel  = 3'd0;
      alu_op   = 4'b0000;
      halted   = 1'b0;
      // Operand selects stay stable from EXEC through MEM and WB.
      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
         case (opcode_q)
            OPC_OP:    alu_op = {f7b5_q, funct3_q};
            OPC_OPIMM: begin
               op2_sel = 1'b1;
               imm_sel = 3'd0;
               alu_op  = {f7b5_q & (funct3_q == 3'b101), funct3_q};
            end
            OPC_LOAD, OPC_JALR: begin
               op2_sel = 1'b1;
               imm_sel = 3'd0;
            end
            OPC_STORE: begin
               op2_sel = 1'b1;
               imm_sel = 3'd1;
            end
            OPC_AUIPC: begin
               op1_sel = 1'b1;
               op2_sel = 1'b1;
               imm_sel = 3'd3;
            end
            OPC_LUI:    imm_sel = 3'd3;
            OPC_JAL:    imm_sel = 3'd4;
            OPC_BRANCH: imm_sel = 3'd2;
            default:    imm_sel = 3'd0;
         endcase
      end
      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            ir_we    = imem_ready;
         end
         S_DECODE: begin
`ifndef CTRL_ILLEGAL_HALT_EN
            pc_we = (opcode_q != OPC_LUI) && !opc_known;
`endif
         end
         S_EXEC: begin
            if (opcode_q == OPC_BRANCH) begin
               pc_we  = 1'b1;
               sel_pc = br_taken ? 2'b10 : 2'b00;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (opcode_q == OPC_STORE);
            pc_we    = dmem_ready && (opcode_q == OPC_STORE);
         end
         S_WB: begin
            rf_we = 1'b1;
            pc_we = 1'b1;
            case (opcode_q)
               OPC_LUI:  wb_sel = 2'b11;
               OPC_LOAD: wb_sel = 2'b01;
               OPC_JAL: begin
                  wb_sel = 2'b00;
                  sel_pc = 2'b01;
               end
               OPC_JALR: begin
                  wb_sel = 2'b00;
                  sel_pc = 2'b11;
               end
               default:  wb_sel = 2'b10;
            endcase
         end
         S_HALT:  halted = 1'b1;
         default: halted = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Directed bench for rv32_multicycle_ctrl: walks each instruction class cycle by cycle,
// exercises both watchdog boundaries, halt and reset, with immediate assertions at each check.
module tb_rv32_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic        imem_ready, dmem_ready, br_taken;
   logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we;
   logic [1:0]  sel_pc, wb_sel;
   logic        op1_sel, op2_sel;
   logic [2:0]  imm_sel;
   logic [3:0]  alu_op;
   logic        bus_err, halted;
   logic [31:0] instret;
`ifdef CTRL_ILLEGAL_HALT_EN
   logic        illegal;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;
   int fail_cnt  = 0;
   int exp_ret   = 0;

   rv32_multicycle_ctrl #(.XLEN(32), .WAIT_MAX(15), .WAIT_W(4)) dut (
      .clk(clk), .reset(reset), .instr(instr), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .br_taken(br_taken), .imem_req(imem_req),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we),
      .rf_we(rf_we), .sel_pc(sel_pc), .wb_sel(wb_sel), .op1_sel(op1_sel),
      .op2_sel(op2_sel), .imm_sel(imm_sel), .alu_op(alu_op), .bus_err(bus_err),
      .halted(halted),
`ifdef CTRL_ILLEGAL_HALT_EN
      .illegal(illegal),
`endif
      .instret(instret)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a word in FETCH with ready high; returns in the DECODE cycle.
   task automatic fetch(input logic [31:0] w);
      instr      = w;
      imem_ready = 1'b1;
      #1;
      chk("fetch_imem_req", imem_req, 1);
      chk("fetch_ir_we", ir_we, 1);
      tick();
      imem_ready = 1'b0;
      #1;
   endtask

   initial begin
      reset = 1'b1; instr = '0; imem_ready = 1'b0; dmem_ready = 1'b0; br_taken = 1'b0;
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("rst_imem_req", imem_req, 1);
      chk("rst_ir_we", ir_we, 0);
      chk("rst_pc_we", pc_we, 0);
      chk("rst_rf_we", rf_we, 0);
      chk("rst_dmem_req", dmem_req, 0);
      chk("rst_dmem_we", dmem_we, 0);
      chk("rst_halted", halted, 0);
      chk("rst_bus_err", bus_err, 0);
      chk("rst_instret", instret, 0);

      // ADDI x1,x0,5
      fetch(32'h00500093);
      chk("addi_dec_pc_we", pc_we, 0);
      chk("addi_dec_imem_req", imem_req, 0);
      tick();
      chk("addi_ex_op2", op2_sel, 1);
      chk("addi_ex_rf_we", rf_we, 0);
      tick();
      chk("addi_wb_rf_we", rf_we, 1);
      chk("addi_wb_pc_we", pc_we, 1);
      chk("addi_wb_sel", wb_sel, 2);
      chk("addi_wb_op2", op2_sel, 1);
      chk("addi_wb_alu", alu_op, 0);
      chk("addi_wb_sel_pc", sel_pc, 0);
      tick(); exp_ret = 1;
      chk("addi_instret", instret, exp_ret);

      // BEQ taken, then not taken
      br_taken = 1'b1;
      fetch(32'h00000063);
      tick();
      chk("beq_t_pc_we", pc_we, 1);
      chk("beq_t_sel_pc", sel_pc, 2);
      chk("beq_t_imm", imm_sel, 2);
      chk("beq_t_rf_we", rf_we, 0);
      tick(); exp_ret++;
      chk("beq_t_instret", instret, exp_ret);
      chk("beq_t_fetch_rf_we", rf_we, 0);
      br_taken = 1'b0;
      fetch(32'h00000063);
      tick();
      chk("beq_n_pc_we", pc_we, 1);
      chk("beq_n_sel_pc", sel_pc, 0);
      chk("beq_n_rf_we", rf_we, 0);
      tick(); exp_ret++;
      chk("beq_n_instret", instret, exp_ret);

      // LUI x1,1 goes straight from DECODE to WB
      fetch(32'h000010b7);
      tick();
      chk("lui_rf_we", rf_we, 1);
      chk("lui_wb_sel", wb_sel, 3);
      chk("lui_sel_pc", sel_pc, 0);
      tick(); exp_ret++;
      chk("lui_instret", instret, exp_ret);

      // LW x1,0(x2) with dmem_ready delayed three cycles
      fetch(32'h00012083);
      tick();
      chk("lw_ex_op2", op2_sel, 1);
      chk("lw_ex_imm", imm_sel, 0);
      chk("lw_ex_alu", alu_op, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("lw_mem_req", dmem_req, 1);
         chk("lw_mem_we", dmem_we, 0);
         chk("lw_mem_pc_we", pc_we, 0);
         tick();
      end
      dmem_ready = 1'b1;
      #1;
      chk("lw_mem_req_last", dmem_req, 1);
      chk("lw_mem_we_last", dmem_we, 0);
      chk("lw_mem_pc_we_last", pc_we, 0);
      tick();
      dmem_ready = 1'b0;
      #1;
      chk("lw_wb_sel", wb_sel, 1);
      chk("lw_wb_rf_we", rf_we, 1);
      chk("lw_wb_dmem_req", dmem_req, 0);
      tick(); exp_ret++;
      chk("lw_instret", instret, exp_ret);

      // SW x2,0(x1) with ready immediately
      fetch(32'h0020a023);
      tick();
      chk("sw_ex_imm", imm_sel, 1);
      chk("sw_ex_op2", op2_sel, 1);
      tick();
      dmem_ready = 1'b1;
      #1;
      chk("sw_mem_we", dmem_we, 1);
      chk("sw_mem_pc_we", pc_we, 1);
      chk("sw_mem_sel_pc", sel_pc, 0);
      chk("sw_mem_rf_we", rf_we, 0);
      tick();
      dmem_ready = 1'b0;
      #1; exp_ret++;
      chk("sw_instret", instret, exp_ret);
      chk("sw_back_fetch", imem_req, 1);

      // JALR x1,0(x2)
      fetch(32'h000100e7);
      tick(); tick();
      chk("jalr_rf_we", rf_we, 1);
      chk("jalr_wb_sel", wb_sel, 0);
      chk("jalr_sel_pc", sel_pc, 3);
      chk("jalr_op2", op2_sel, 1);
      chk("jalr_imm", imm_sel, 0);
      tick(); exp_ret++;
      chk("jalr_instret", instret, exp_ret);

      // AUIPC x1,0
      fetch(32'h00000097);
      tick();
      chk("auipc_op1", op1_sel, 1);
      chk("auipc_imm", imm_sel, 3);
      chk("auipc_op2", op2_sel, 1);
      tick();
      chk("auipc_wb_sel", wb_sel, 2);
      tick(); exp_ret++;
      chk("auipc_instret", instret, exp_ret);

      // SUB, SRAI, and ADDI whose immediate sets bit 30
      fetch(32'h40208033);
      tick();
      chk("sub_alu", alu_op, 4'b1000);
      chk("sub_op2", op2_sel, 0);
      chk("sub_op1", op1_sel, 0);
      tick(); tick(); exp_ret++;
      fetch(32'h4030d093);
      tick();
      chk("srai_alu", alu_op, 4'b1101);
      chk("srai_op2", op2_sel, 1);
      tick(); tick(); exp_ret++;
      fetch(32'h40000093);
      tick();
      chk("addi_b30_alu", alu_op, 4'b0000);
      tick(); tick(); exp_ret++;
      chk("alu_group_instret", instret, exp_ret);

      // JAL x1,0
      fetch(32'h000000ef);
      tick(); tick();
      chk("jal_sel_pc", sel_pc, 1);
      chk("jal_imm", imm_sel, 4);
      chk("jal_wb_sel", wb_sel, 0);
      chk("jal_rf_we", rf_we, 1);
      tick(); exp_ret++;
      chk("jal_instret", instret, exp_ret);

      // Unknown opcode 0x7F
      fetch(32'h0000007f);
`ifdef CTRL_ILLEGAL_HALT_EN
      chk("ill_dec_pc_we", pc_we, 0);
      tick();
      chk("ill_halted", halted, 1);
      chk("ill_flag", illegal, 1);
      chk("ill_pc_we", pc_we, 0);
      chk("ill_instret", instret, exp_ret);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1; exp_ret = 0;
      chk("ill_rst_flag", illegal, 0);
`else
      chk("nop_pc_we", pc_we, 1);
      chk("nop_sel_pc", sel_pc, 0);
      chk("nop_rf_we", rf_we, 0);
      tick();
      chk("nop_fetch", imem_req, 1);
      chk("nop_instret", instret, exp_ret);
`endif

      // imem_ready arrives exactly at the wait limit: no error
      instr = 32'h000010b7;
      for (int i = 0; i < 15; i++) begin
         chk("iwait_req", imem_req, 1);
         tick();
      end
      chk("iwait_bus_err_pre", bus_err, 0);
      fetch(32'h000010b7);
      chk("iwait_bus_err", bus_err, 0);
      chk("iwait_halted", halted, 0);
      tick(); tick(); exp_ret++;
      chk("iwait_instret", instret, exp_ret);

      // SW with dmem_ready low for 16 cycles: watchdog fires
      fetch(32'h0020a023);
      tick(); tick();
      for (int i = 0; i < 16; i++) begin
         chk("dwait_req", dmem_req, 1);
         chk("dwait_halted", halted, 0);
         tick();
      end
      chk("to_bus_err", bus_err, 1);
      chk("to_halted", halted, 1);
      chk("to_dmem_req", dmem_req, 0);
      chk("to_dmem_we", dmem_we, 0);
      chk("to_imem_req", imem_req, 0);
      chk("to_pc_we", pc_we, 0);
      chk("to_instret", instret, exp_ret);
      dmem_ready = 1'b1; imem_ready = 1'b1;
      tick(); tick(); tick();
      chk("to_still_halted", halted, 1);
      chk("to_still_bus_err", bus_err, 1);
      chk("to_still_no_req", imem_req, 0);
      dmem_ready = 1'b0; imem_ready = 1'b0;

      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1; exp_ret = 0;
      chk("post_rst_halted", halted, 0);
      chk("post_rst_bus_err", bus_err, 0);
      chk("post_rst_instret", instret, exp_ret);

      // Reset in the middle of a load access
      fetch(32'h00012083);
      tick(); tick();
      chk("mid_mem_req", dmem_req, 1);
      reset = 1'b1;
      tick();
      chk("mid_dmem_req", dmem_req, 0);
      chk("mid_rf_we", rf_we, 0);
      chk("mid_pc_we", pc_we, 0);
      chk("mid_imem_req", imem_req, 1);
      reset = 1'b0;
      tick();
      chk("mid_rf_we_after", rf_we, 0);
      chk("mid_instret", instret, exp_ret);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/rv32_multicycle_ctrl.md
Name: rv32_multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I core datapath. Sequences fetch, decode, execute, memory and writeback over several clocks. Drives the datapath mux selects (PC, writeback, operand, immediate), the register-file and data-memory write enables, and the memory request handshakes. Also keeps a retired-instruction counter and a memory-wait watchdog.

Parameters:
XLEN, 32, width of the instret counter
WAIT_MAX, 15, maximum number of cycles that imem_ready/dmem_ready may stay low before a bus error is raised
WAIT_W, 4, width of the wait counter; must satisfy 2**WAIT_W > WAIT_MAX

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
instr  input  32  instruction word from program memory; valid when imem_ready=1
imem_ready  input  1  program memory data valid
dmem_ready  input  1  data memory access complete
br_taken  input  1  branch comparator result from the datapath (registered rs1/rs2)
imem_req  output  1  program memory read request
dmem_req  output  1  data memory request
dmem_we  output  1  data memory write (store)
ir_we  output  1  capture instruction into the datapath IR
pc_we  output  1  update the program counter
rf_we  output  1  register file write
sel_pc  output  2  00 pc+4, 01 jal target, 10 branch target, 11 jalr (ALU result)
wb_sel  output  2  00 pc+4, 01 dmem data, 10 ALU, 11 U-immediate
op1_sel  output  1  0 rs1, 1 pc
op2_sel  output  1  0 rs2, 1 immediate
imm_sel  output  3  0 I, 1 S, 2 B, 3 U, 4 J
alu_op  output  4  {funct7[5], funct3}; 0000 = ADD
bus_err  output  1  sticky flag: watchdog expired
halted  output  1  FSM is in HALT
instret  output  XLEN  count of retired instructions

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Reset (sync) forces FETCH and clears instret, the wait counter, bus_err and the latched opcode/funct fields.
- All outputs are decoded combinationally from the state and the latched fields. In the cycle after reset: imem_req=1 and every other enable is 0.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_we=1; latch opcode, funct3, funct7[5]; go to DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE: one cycle, no enables. Next state:
  - LUI -> WB.
  - OP, OP-IMM, AUIPC, LOAD, STORE, BRANCH, JAL, JALR -> EXEC.
  - Any other opcode -> FETCH with pc_we=1, sel_pc=00; treated as a NOP and not counted in instret.
- EXEC selects:
  - OP: op1=rs1, op2=rs2, alu_op={f7[5],f3}.
  - OP-IMM: op2=imm, imm_sel=I; alu_op={f7[5]&(f3==101), f3}.
  - LOAD/JALR: imm I, ADD. STORE: imm S, ADD.
  - AUIPC: op1=pc, imm U, ADD.
- EXEC next state:
  - LOAD/STORE -> MEM.
  - OP/OP-IMM/AUIPC/JAL/JALR -> WB.
  - BRANCH retires here: pc_we=1, imm_sel=B, sel_pc = br_taken ? 10 : 00 -> FETCH.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE; operand selects held as in EXEC.
  - On dmem_ready: LOAD -> WB; STORE retires with pc_we=1, sel_pc=00 -> FETCH.
  - Otherwise wait and increment the wait counter.
- WB: rf_we=1, pc_we=1 in the same cycle, then -> FETCH.
  - LUI: wb 11, sel_pc 00.
  - LOAD: wb 01, sel_pc 00.
  - OP/OP-IMM/AUIPC: wb 10, sel_pc 00.
  - JAL: wb 00, imm J, sel_pc 01.
  - JALR: wb 00, sel_pc 11, with EXEC selects held.
- Minimum latencies (ready immediately):
  - Branch: 3 cycles.
  - LUI: 3 cycles.
  - ALU/AUIPC/JAL/JALR: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- instret increments by 1 in every cycle where a counted instruction retires (pc_we=1 excluding the DECODE-NOP). It wraps modulo 2**XLEN.
- Wait counter:
  - Clears on every state change.
  - When it equals WAIT_MAX while ready is still low: set bus_err, go to HALT, drop the request.
  - Ready arriving in the same cycle as the limit wins; there is no error.
- HALT: every enable and request is 0, halted=1. Only reset exits HALT.
- Reset mid-access: the request drops in the next cycle and no write enable is issued.

Optional Feature:
CTRL_ILLEGAL_HALT_EN.
- Defined: an unknown opcode in DECODE goes to HALT and sets a sticky illegal-flag output `illegal` (1 bit, reset 0), with no pc_we.
- Undefined: unknown opcodes act as NOP (pc_we, sel_pc=00 -> FETCH), and the `illegal` port is absent.

Test Plan:
1. ADDI x1,x0,5 (0x00500093), ready held high -> ir_we at cycle 1; rf_we+pc_we at cycle 4 with wb_sel=10, op2_sel=1, alu_op=0000; instret=1.
2. BEQ with br_taken=1, then with br_taken=0 -> pc_we at cycle 3 with sel_pc=10, then sel_pc=00; rf_we never asserted.
3. LW with dmem_ready delayed 3 cycles -> dmem_req held 4 cycles with dmem_we=0; WB wb_sel=01; total latency 8 cycles.
4. SW with dmem_ready low for 16 cycles (WAIT_MAX=15) -> bus_err=1, halted=1, dmem_req=0; stays halted until reset.
5. JALR x1,0(x2) -> WB asserts rf_we, wb_sel=00, sel_pc=11; AUIPC -> op1_sel=1, imm_sel=3.
6. Opcode 0x7F: without the macro, NOP in 2 cycles with instret unchanged; with CTRL_ILLEGAL_HALT_EN, illegal=1, halted=1, pc_we never asserted.
